// File: rtl/ccg_exhaustive_sequencer.sv
// Exhaustive input sequencer for a small combinational CUT with MISR signature capture.
// Optional golden-output comparison is enabled by defining CCG_SEQ_CMP_EN.
module ccg_exhaustive_sequencer #(
    parameter int unsigned           N_IN   = 4,
    parameter int unsigned           N_OUT  = 15,
    parameter int unsigned           SIG_W  = 16,
    parameter logic [SIG_W-1:0]      POLY   = 16'h1021,
    parameter logic [SIG_W-1:0]      SEED   = '0,
    parameter int unsigned           SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
`ifdef CCG_SEQ_CMP_EN
    input  logic [N_OUT-1:0]  exp_f,
    output logic [N_IN:0]     err_cnt,
    output logic [N_IN-1:0]   first_err_idx,
`endif
    output logic [N_IN-1:0]   dut_x,
    input  logic [N_OUT-1:0]  dut_f,
    output logic              busy,
    output logic              done,
    output logic [N_IN-1:0]   vec_idx,
    output logic [SIG_W-1:0]  signature
);

    if (N_IN < 1 || N_IN > 8 || N_OUT < 1 || N_OUT > SIG_W || SETTLE > 255) begin : g_bad_cfg
        $error("ccg_exhaustive_sequencer: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

    state_t            state;
    logic [7:0]        settle_cnt;
    logic [SIG_W-1:0]  f_ext;
    logic [SIG_W-1:0]  sig_next;

    always_comb begin
        f_ext              = '0;
        f_ext[N_OUT-1:0]   = dut_f;
        sig_next = {signature[SIG_W-2:0], 1'b0}
                 ^ (signature[SIG_W-1] ? POLY : '0)
                 ^ f_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            dut_x         <= '0;
            vec_idx       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            signature     <= SEED;
            settle_cnt    <= '0;
`ifdef CCG_SEQ_CMP_EN
            err_cnt       <= '0;
            first_err_idx <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        vec_idx   <= '0;
                        dut_x     <= '0;
                        signature <= SEED;
                        busy      <= 1'b1;
                        state     <= APPLY;
`ifdef CCG_SEQ_CMP_EN
                        err_cnt       <= '0;
                        first_err_idx <= '0;
`endif
                    end
                end
                APPLY: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        settle_cnt <= 8'(SETTLE);
                        state      <= (SETTLE == 0) ? CAPTURE : WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                        if (settle_cnt <= 8'd1) begin
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    // abort wins over the capture so partial results stay untouched
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        signature <= sig_next;
`ifdef CCG_SEQ_CMP_EN
                        if (dut_f != exp_f) begin
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                            if (err_cnt == '0) begin
                                first_err_idx <= vec_idx;
                            end
                        end
`endif
                        if (vec_idx == '1) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            vec_idx <= vec_idx + 1'b1;
                            dut_x   <= vec_idx + 1'b1;
                            state   <= APPLY;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
